alu_spi_frontend: RTL
=====================

// Module: alu_spi_frontend
// PURPOSE
//  SPI-mode-0 slave that receives an operation frame {opcode, A, B} from the external master.
//  Presents the fields as registered operands to the 4-bit ALU, then captures the ALU result and NZCV flags.
//  Returns the captured response to the master, MSB first, during the next SPI frame.
//  Sits directly upstream of the ALU and also closes the loop back to the master. All logic runs on clk; SPI pins are oversampled.
// PARAMETERS
//  WIDTH        4  operand/result width; request frame = 2*WIDTH+2 bits, response frame = WIDTH+4 bits
//  SYNC_STAGES  2  flip-flop synchronizer depth on spi_sck/spi_cs_n/spi_mosi (>=2)
// PORTS
//  clk         in   1      system clock; must be >= 4x SCK frequency
//  rst         in   1      asynchronous, active-high reset
//  spi_sck     in   1      SPI clock from master (CPOL=0, CPHA=0)
//  spi_cs_n    in   1      chip select, active low
//  spi_mosi    in   1      serial data from master
//  spi_miso    out  1      serial data to master
//  alu_result  in   WIDTH  ALU result
//  alu_n/z/c/v in   1 each ALU flags
//  A, B        out  WIDTH  registered operands to ALU
//  opcode      out  2      registered opcode to ALU (00 add, 01 sub, 10 and, 11 or)
//  op_valid    out  1      1-cycle pulse when A/B/opcode take new values
//  frame_err   out  1      1-cycle pulse on aborted (short) frame
// BEHAVIOUR
//  Reset: A=B=0, opcode=00, op_valid=0, frame_err=0, spi_miso=0, tx_reg=0, bit_cnt=0, state=IDLE.
//   Reset is asynchronous and may assert mid-frame: partial data is discarded, and the next frame starts clean after the master re-asserts CS.
//  Input conditioning: SCK, CS_n and MOSI each pass through SYNC_STAGES flops.
//   A further flop on SCK/CS yields sck_rise, sck_fall, cs_fall and cs_rise single-cycle strobes.
//  States:
//   IDLE    -> SHIFT on cs_fall: bit_cnt<=0, rx_reg<=0, spi_miso<=tx_reg[MSB].
//   SHIFT   - on sck_rise: rx_reg<={rx_reg,mosi_s}, bit_cnt++ (saturating).
//           - on sck_fall: tx_reg shifts left with 0 fill, spi_miso<=new tx_reg[MSB].
//           -> LOAD when bit_cnt reaches 2*WIDTH+2.
//           -> IDLE on cs_rise with bit_cnt < 2*WIDTH+2: frame_err pulses 1 cycle; A/B/opcode unchanged.
//   LOAD    - one cycle: {opcode,A,B} <= rx_reg (opcode = first 2 bits, then A MSB-first, then B MSB-first); op_valid=1.
//           -> CAPTURE.
//   CAPTURE - one cycle: tx_reg <= {alu_n,alu_z,alu_c,alu_v,alu_result}.
//           -> WAIT_CS.
//   WAIT_CS - extra SCK edges are ignored for rx; tx keeps shifting (zeros once exhausted).
//           -> IDLE on cs_rise (no error).
//  Timing:
//   op_valid asserts 1 cycle after the sck_rise strobe of the last bit, i.e. SYNC_STAGES+2 clk after the physical edge.
//   ALU outputs are sampled exactly 1 cycle after op_valid, so the combinational ALU settles within 1 clk.
//  Response: the frame after an operation returns WIDTH+4 bits {N,Z,C,V,result}, then zeros.
//   The first response after reset is all zeros.
//  spi_miso=0 whenever state==IDLE (no tristate; board-level mux handles sharing).
//  cs_fall while a short frame is in SHIFT cannot occur without a preceding cs_rise; the cs_rise abort rule applies.
//  Simultaneous cs_rise and last sck_rise in the same clk: the bit is accepted, the frame completes (LOAD), no frame_err.
//  Outputs A/B/opcode hold their last values indefinitely between frames.
// TESTING
//  1 Frame 00_0011_0101 -> A=4'h3, B=4'h5, opcode=00; op_valid high exactly 1 cycle; frame_err=0.
//  2 Bench drives alu_result=4'h8, NZCV=0001 after op_valid; next 10-bit frame -> MISO bits 0,0,0,1,1,0,0,0,0,0.
//  3 Frame 01_0010_0111 -> opcode=01, A=2, B=7; then NZCV=1000, result=4'hB
//    -> next frame returns 1,0,0,0,1,0,1,1 then zeros.
//  4 CS raised after 6 bits -> frame_err 1-cycle pulse, no op_valid, A/B/opcode keep previous values; next full frame succeeds.
//  5 rst asserted mid-frame (bit 5) -> all outputs 0 immediately (async); following 10-bit frame 11_1111_0000 -> A=F, B=0, opcode=11.
//  6 12 SCK pulses in one CS window with frame 10_1010_1100 -> A=A, B=C, opcode=10; single op_valid; bits 11-12 ignored.

Source files
------------

// File: rtl/alu_spi_frontend_if.sv
// Signal bundle between the SPI master / 4-bit ALU and the alu_spi_frontend slave.
// The slave modport is the frontend's view; master is the view of whatever drives it.
interface alu_spi_frontend_if #(
   parameter int WIDTH = 4
);
   logic             spi_sck;
   logic             spi_cs_n;
   logic             spi_mosi;
   logic             spi_miso;
   logic [WIDTH-1:0] alu_result;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       opcode;
   logic             op_valid;
   logic             frame_err;

   modport slave (
      input  spi_sck, spi_cs_n, spi_mosi,
      input  alu_result, alu_n, alu_z, alu_c, alu_v,
      output spi_miso, A, B, opcode, op_valid, frame_err
   );

   modport master (
      output spi_sck, spi_cs_n, spi_mosi,
      output alu_result, alu_n, alu_z, alu_c, alu_v,
      input  spi_miso, A, B, opcode, op_valid, frame_err
   );
endinterface

// File: rtl/alu_spi_frontend.sv
// SPI mode-0 slave: receives {opcode, A, B}, drives them to the ALU, captures
// {N,Z,C,V,result} and returns it MSB first during the following frame.
module alu_spi_frontend #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   alu_spi_frontend_if.slave   bus
);

   localparam int FRAME_BITS = 2 * WIDTH + 2;
   localparam int RESP_BITS  = WIDTH + 4;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LOAD,
      ST_CAPTURE,
      ST_WAIT_CS
   } state_e;

   // Input synchronizers plus one extra delay flop for edge detection.
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_dly_q;
   logic                   cs_dly_q;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_fall, cs_rise;

   state_e                 state_q,     state_d;
   logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
   logic [FRAME_BITS-2:0]  rx_q,        rx_d;
   logic [RESP_BITS-2:0]   tx_q,        tx_d;
   logic [RESP_BITS-1:0]   resp_q,      resp_d;
   logic                   miso_q,      miso_d;
   logic [WIDTH-1:0]       a_q,         a_d;
   logic [WIDTH-1:0]       b_q,         b_d;
   logic [1:0]             opcode_q,    opcode_d;
   logic                   op_valid_q,  op_valid_d;
   logic                   frame_err_q, frame_err_d;

   logic [FRAME_BITS-1:0]  rx_full;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;
   assign cs_fall  = ~cs_s & cs_dly_q;
   assign cs_rise  = cs_s & ~cs_dly_q;

   // CS resets low so a CS already low when reset releases (mid-frame reset)
   // never fakes a cs_fall; the frame only restarts after a real CS toggle.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_dly_q   <= 1'b0;
         cs_dly_q    <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  bus.spi_sck};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
         sck_dly_q   <= sck_s;
         cs_dly_q    <= cs_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         resp_q      <= '0;
         miso_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         opcode_q    <= 2'b00;
         op_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         resp_q      <= resp_d;
         miso_q      <= miso_d;
         a_q         <= a_d;
         b_q         <= b_d;
         opcode_q    <= opcode_d;
         op_valid_q  <= op_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_full = {rx_q, mosi_s};

   // miso_q is the head of the outgoing word; tx_q holds the bits still to go.
   // The captured response waits in resp_q until the next frame starts, so
   // SCK edges at the tail of the request frame cannot consume it.
   // NOTE: every signal gets its default before the case so no path leaves a
   // variable unassigned, which would infer a latch.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      resp_d      = resp_q;
      miso_d      = miso_q;
      a_d         = a_q;
      b_d         = b_q;
      opcode_d    = opcode_q;
      op_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if (sck_fall && state_q != ST_IDLE) begin
         miso_d = tx_q[RESP_BITS-2];
         tx_d   = {tx_q[RESP_BITS-3:0], 1'b0};
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               rx_d      = '0;
               miso_d    = resp_q[RESP_BITS-1];
               tx_d      = resp_q[RESP_BITS-2:0];
               resp_d    = '0;
            end
         end

         ST_SHIFT: begin
            if (sck_rise) begin
               rx_d = rx_full[FRAME_BITS-2:0];
               if (bit_cnt_q < CNT_W'(FRAME_BITS)) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                  opcode_d   = rx_full[FRAME_BITS-1 -: 2];
                  a_d        = rx_full[2*WIDTH-1 -: WIDTH];
                  b_d        = rx_full[WIDTH-1:0];
                  op_valid_d = 1'b1;
                  state_d    = ST_LOAD;
               end
            end
            // A completing bit wins over a simultaneous CS release.
            if (cs_rise && state_d == ST_SHIFT) begin
               frame_err_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         ST_LOAD: begin
            state_d = ST_CAPTURE;
         end

         ST_CAPTURE: begin
            resp_d  = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_result};
            state_d = ST_WAIT_CS;
         end

         ST_WAIT_CS: begin
            if (cs_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d == ST_IDLE) begin
         miso_d = 1'b0;
      end
   end

   assign bus.spi_miso  = miso_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.opcode    = opcode_q;
   assign bus.op_valid  = op_valid_q;
   assign bus.frame_err = frame_err_q;

endmodule
